// File: rtl/mmix_avs_pkg.sv
// Shared constants and types for the Avalon-MM memory responder.
package mmix_avs_pkg;

    localparam int unsigned AVS_ADDR_W = 28;
    localparam int unsigned AVS_DATA_W = 64;
    localparam int unsigned AVS_BE_W   = 8;

    localparam int unsigned AVS_RD_LAT_MIN = 1;
    localparam int unsigned AVS_RD_LAT_MAX = 4;

    localparam int unsigned AVS_CNT_W = 4;

    typedef enum logic [1:0] {
        AVS_IDLE,
        AVS_WAIT,
        AVS_GRANT
    } avs_state_e;

    typedef struct packed {
        logic                  valid;
        logic [AVS_DATA_W-1:0] data;
    } avs_rd_beat_t;

endpackage

// File: rtl/avs_read_pipe.sv
// Valid/data delay line returning read beats DEPTH cycles after capture.
module avs_read_pipe
    import mmix_avs_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  avs_rd_beat_t in_beat,
    output avs_rd_beat_t out_beat
);

    avs_rd_beat_t stage [DEPTH];

    // Asynchronous clear drops every in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_beat;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_beat = stage[DEPTH-1];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave backed by a 64-bit byte-enabled on-chip memory.
// Wait-state insertion is built only when AVS_WAITSTATE_EN is defined.
module avalon_mem_responder
    import mmix_avs_pkg::*;
#(
    parameter int unsigned WORD_ADDR_W  = 12,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [AVS_ADDR_W-1:0] d_address,
    input  logic [AVS_BE_W-1:0]   d_byteenable,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [AVS_DATA_W-1:0] d_writedata,
    output logic                  d_waitrequest,
    output logic [AVS_DATA_W-1:0] d_readdata,
    output logic                  d_readdatavalid
);

    localparam int unsigned DEPTH = 1 << WORD_ADDR_W;
    localparam int unsigned PIPE_DEPTH =
        (READ_LATENCY < AVS_RD_LAT_MIN) ? AVS_RD_LAT_MIN :
        (READ_LATENCY > AVS_RD_LAT_MAX) ? AVS_RD_LAT_MAX : READ_LATENCY;

    logic                   cmd;
    logic                   accept;
    logic [WORD_ADDR_W-1:0] word_idx;
    logic [AVS_DATA_W-1:0]  mem [DEPTH];
    avs_rd_beat_t           rd_beat;
    avs_rd_beat_t           rsp_beat;

    assign cmd      = d_read | d_write;
    assign word_idx = d_address[WORD_ADDR_W+2:3];

`ifdef AVS_WAITSTATE_EN
    avs_state_e           state;
    logic [AVS_CNT_W-1:0] cnt;

    // The IDLE presentation cycle is itself the first stall cycle, so WAIT
    // counts the remaining WAIT_CYCLES-1 stalls before granting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= AVS_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                AVS_IDLE: begin
                    if (cmd && (WAIT_CYCLES != 0)) begin
                        if (WAIT_CYCLES == 1) begin
                            state <= AVS_GRANT;
                        end else begin
                            state <= AVS_WAIT;
                            cnt   <= AVS_CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                AVS_WAIT: begin
                    if (!cmd) begin
                        state <= AVS_IDLE;
                        cnt   <= '0;
                    end else if (cnt == AVS_CNT_W'(1)) begin
                        state <= AVS_GRANT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                AVS_GRANT: state <= AVS_IDLE;
                default:   state <= AVS_IDLE;
            endcase
        end
    end

    assign d_waitrequest = cmd & (state != AVS_GRANT) & (WAIT_CYCLES != 0);
`else
    assign d_waitrequest = 1'b0;
`endif

    assign accept = cmd & ~d_waitrequest;

    // Only enabled byte lanes are written; write wins when read is also high.
    always_ff @(posedge clk) begin
        if (accept && d_write) begin
            for (int i = 0; i < int'(AVS_BE_W); i++) begin
                if (d_byteenable[i]) begin
                    mem[word_idx][8*i +: 8] <= d_writedata[8*i +: 8];
                end
            end
        end
    end

    assign rd_beat.valid = accept & d_read & ~d_write;
    assign rd_beat.data  = rd_beat.valid ? mem[word_idx] : '0;

    avs_read_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_read_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_beat  (rd_beat),
        .out_beat (rsp_beat)
    );

    assign d_readdata      = rsp_beat.data;
    assign d_readdatavalid = rsp_beat.valid;

    // Address bits outside the word index alias by design.
    logic unused_bits;
    assign unused_bits = ^{d_address, 1'(WAIT_CYCLES)};

endmodule
